// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit among NREQ requesters.
// Optional LU_ARB_PERF_EN adds saturating op_count/err_count outputs.
module logic_unit_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   input  logic [NREQ*3-1:0]       req_op,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [WIDTH-1:0]        res_data,
   output logic [IDW-1:0]          res_id,
   output logic                    res_err
`ifdef LU_ARB_PERF_EN
   ,
   output logic [15:0]             op_count,
   output logic [7:0]              err_count
`endif
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

   state_t           state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [IDW-1:0]   res_id_q, res_id_d;
   logic             res_err_q, res_err_d;

   logic [WIDTH-1:0] a_arr [NREQ];
   logic [WIDTH-1:0] b_arr [NREQ];
   logic [2:0]       op_arr [NREQ];

   logic             win_found;
   logic [IDW-1:0]   win_idx;
   logic             can_accept;
   logic             accept;
   logic [WIDTH:0]   lu_result;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
         assign op_arr[gi] = req_op[gi*3 +: 3];
      end
   endgenerate

   // Index base+k modulo NREQ, valid for non-power-of-two NREQ.
   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input logic [IDW:0] k);
      logic [IDW:0] sum;
      sum = {1'b0, base} + k;
      if (sum >= NREQ_W)
         sum = sum - NREQ_W;
      return sum[IDW-1:0];
   endfunction

   // Returns {err, data}; illegal opcodes yield zero data with err set.
   function automatic logic [WIDTH:0] lu_eval(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0]       op);
      logic [WIDTH:0] r;
      r = '0;
      case (op)
         3'd0:    r[WIDTH-1:0] = a & b;
         3'd1:    r[WIDTH-1:0] = a | b;
         3'd2:    r[WIDTH-1:0] = ~(a & b);
         3'd3:    r[WIDTH-1:0] = ~(a | b);
         3'd4:    r[WIDTH-1:0] = a ^ b;
         3'd5:    r[WIDTH-1:0] = ~(a ^ b);
         default: r[WIDTH]     = 1'b1;
      endcase
      return r;
   endfunction

   // Search starts one past the last grant so every requester gets a turn.
   always_comb begin
      logic [IDW-1:0] idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = wrap_add(last_q, (IDW+1)'(k));
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   assign lu_result = lu_eval(a_arr[win_idx], b_arr[win_idx], op_arr[win_idx]);

   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      can_accept = (state_q == ST_EMPTY) || res_ready;
      // Ready is suppressed while reset is held even though the state reads EMPTY.
      accept     = rst_n && win_found && can_accept;
      if (accept)
         req_ready[win_idx] = 1'b1;
      case (state_q)
         ST_EMPTY: begin
            if (accept)
               state_d = ST_FULL;
         end
         ST_FULL: begin
            if (accept)
               state_d = ST_FULL;
            else if (res_ready)
               state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      last_d     = last_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      res_err_d  = res_err_q;
      if (accept) begin
         last_d     = win_idx;
         res_data_d = lu_result[WIDTH-1:0];
         res_id_d   = win_idx;
         res_err_d  = lu_result[WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_EMPTY;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q     <= IDW'(NREQ - 1);
         res_data_q <= '0;
         res_id_q   <= '0;
         res_err_q  <= 1'b0;
      end else begin
         last_q     <= last_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         res_err_q  <= res_err_d;
      end
   end

   assign res_valid = (state_q == ST_FULL);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign res_err   = res_err_q;

`ifdef LU_ARB_PERF_EN
   logic [15:0] op_count_q, op_count_d;
   logic [7:0]  err_count_q, err_count_d;

   always_comb begin
      op_count_d  = op_count_q;
      err_count_d = err_count_q;
      if (accept && (op_count_q != 16'hFFFF))
         op_count_d = op_count_q + 16'd1;
      if (accept && lu_result[WIDTH] && (err_count_q != 8'hFF))
         err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q  <= '0;
         err_count_q <= '0;
      end else begin
         op_count_q  <= op_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign op_count  = op_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a result scoreboard and a round-robin model.
module tb_logic_unit_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*3-1:0]     req_op;
   logic                  res_valid;
   logic                  res_ready;
   logic [WIDTH-1:0]      res_data;
   logic [IDW-1:0]        res_id;
   logic                  res_err;
`ifdef LU_ARB_PERF_EN
   logic [15:0]           op_count;
   logic [7:0]            err_count;
`endif

   always #5 clk = ~clk;

   logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_err   (res_err)
`ifdef LU_ARB_PERF_EN
      ,
      .op_count  (op_count),
      .err_count (err_count)
`endif
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] id;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_mis  = 0;
   int   m_last = NREQ - 1;
   bit   quiet  = 1'b0;
   logic [7:0] sweep_exp [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_op(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op, input int id);
      exp_t e;
      e.id  = id[1:0];
      e.err = (op > 3'd5);
      case (op)
         3'd0:    e.data = a & b;
         3'd1:    e.data = a | b;
         3'd2:    e.data = ~a | ~b;
         3'd3:    e.data = ~a & ~b;
         3'd4:    e.data = a ^ b;
         3'd5:    e.data = a ^ ~b;
         default: e.data = 8'h00;
      endcase
      return e;
   endfunction

   function automatic int pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_op[i*3 +: 3]        = op;
   endtask

   // One clock: check handshake and outputs against the model, then advance past the edge.
   task automatic tick();
      int         w;
      logic [3:0] exp_ready;
      bit         can;
      exp_t       e;
      #2;
      can       = (sb.size() == 0) || res_ready;
      w         = pick(req_valid, m_last);
      exp_ready = (w >= 0 && can) ? (4'b0001 << w) : 4'b0000;
      chk("req_ready", req_ready, exp_ready);
      chk("res_valid", res_valid, sb.size() != 0);
      if (sb.size() != 0 && res_ready) begin
         e = sb.pop_front();
         chk("res_data", res_data, e.data);
         chk("res_id", res_id, e.id);
         chk("res_err", res_err, e.err);
      end
      if (exp_ready != 0) begin
         sb.push_back(ref_op(req_a[w*WIDTH +: WIDTH], req_b[w*WIDTH +: WIDTH], req_op[w*3 +: 3], w));
         m_last = w;
         if (!quiet)
            $display("[%0t] accept id=%0d a=%h b=%h op=%0d", $time, w,
                     req_a[w*WIDTH +: WIDTH], req_b[w*WIDTH +: WIDTH], req_op[w*3 +: 3]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      sb.delete();
      m_last = NREQ - 1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      sweep_exp = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00, 8'h00};
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req_ready", req_ready, 0);
      chk("reset_res_valid", res_valid, 0);
      chk("reset_res_data", res_data, 0);
      chk("reset_res_id", res_id, 0);
      chk("reset_res_err", res_err, 0);

      // Single request from requester 2 right after reset release.
      rst_n     = 1'b1;
      req_valid = 4'b0100;
      set_req(2, 8'hF0, 8'h3C, 3'd4);
      #1;
      chk("t1_ready", req_ready, 4'b0100);
      tick();
      req_valid = 4'b0000;
      chk("t1_valid", res_valid, 1);
      chk("t1_data", res_data, 8'hCC);
      chk("t1_id", res_id, 2);
      chk("t1_err", res_err, 0);
      tick();

      // Round-robin fairness with all requesters active.
      do_reset();
      for (int i = 0; i < NREQ; i++)
         set_req(i, 8'h11 * (i + 1), 8'h0F + 8'(i), 3'(i + 1));
      req_valid = 4'hF;
      res_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr_grant", req_ready, 4'b0001 << (k % NREQ));
         if (k > 0) chk("rr_res_valid", res_valid, 1);
         tick();
      end

      // Backpressure: buffer full, downstream stalled.
      res_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready_low", req_ready, 0);
         tick();
      end
      res_ready = 1'b1;
      #1;
      chk("bp_release_accept", |req_ready, 1);
      tick();
      req_valid = 4'b0000;
      tick();

      // Opcode sweep through requester 1.
      req_valid = 4'b0010;
      for (int op = 0; op < 8; op++) begin
         set_req(1, 8'hA5, 8'h0F, 3'(op));
         tick();
         chk("sweep_data", res_data, sweep_exp[op]);
         chk("sweep_err", res_err, op >= 6);
      end
      req_valid = 4'b0000;
      tick();

      // Reset asserted between edges while a result is pending.
      set_req(0, 8'h12, 8'h34, 3'd1);
      set_req(3, 8'h56, 8'h78, 3'd0);
      req_valid = 4'b0001;
      res_ready = 1'b0;
      tick();
      req_valid = 4'b1001;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_res_valid", res_valid, 0);
      chk("mr_res_data", res_data, 0);
      chk("mr_res_id", res_id, 0);
      chk("mr_res_err", res_err, 0);
      chk("mr_req_ready", req_ready, 0);
      sb.delete();
      m_last = NREQ - 1;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      res_ready = 1'b1;
      #1;
      chk("mr_priority", req_ready, 4'b0001);
      tick();
      tick();
      req_valid = 4'b0000;
      tick();
      tick();

`ifdef LU_ARB_PERF_EN
      do_reset();
      quiet     = 1'b1;
      req_valid = 4'b0001;
      for (int n = 0; n < 300; n++) begin
         set_req(0, 8'(n), 8'h5A, (n == 100 || n == 200) ? 3'd6 : 3'(n % 6));
         tick();
      end
      chk("perf_op_count", op_count, 300);
      chk("perf_err_count", err_count, 2);
      set_req(0, 8'h33, 8'h44, 3'd4);
      for (int n = 0; n < 70000; n++)
         tick();
      chk("perf_op_sat", op_count, 16'hFFFF);
      chk("perf_err_hold", err_count, 2);
      req_valid = 4'b0000;
      quiet     = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one registered two-input bitwise logic unit (AND, OR, NAND, NOR, XOR, XNOR) among `NREQ` requesters. Each requester presents operands and an opcode over a valid/ready handshake. The block grants one request per cycle, evaluates it, and returns the result with the requester's ID through a one-deep output buffer. It sits between the gate datapath and any client that needs bitwise operations.

## Interface
- `NREQ`, 4: number of requesters, range 2–8.
- `WIDTH`, 8: operand and result width in bits.
- `IDW`, $clog2(NREQ): width of the requester ID.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  bit i set: requester i presents a request.
- `req_ready`  out  NREQ  bit i set: request i is accepted this cycle (one-hot or zero).
- `req_a`  in  NREQ*WIDTH  operand A of requester i, at bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, packed the same way.
- `req_op`  in  NREQ*3  opcode of requester i, at bits [i*3 +: 3].
- `res_valid`  out  1  result buffer holds a result.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  WIDTH  result value.
- `res_id`  out  IDW  index of the requester that produced the result.
- `res_err`  out  1  the opcode was illegal.

## Operation
- Opcodes:
  - 0: AND
  - 1: OR
  - 2: NAND
  - 3: NOR
  - 4: XOR
  - 5: XNOR
  - 6 and 7: illegal. `res_data` = 0 and `res_err` = 1.
- Buffer FSM has two states, EMPTY and FULL. Reset enters EMPTY.
- `can_accept` = EMPTY, or (FULL and `res_ready`).
- Arbitration:
  - Round-robin pointer `last` (IDW bits) records the most recently granted requester. Reset value is NREQ-1, so requester 0 has top priority first.
  - The winner is the first i with `req_valid[i]` set, searching from `last`+1 upward and wrapping modulo NREQ.
  - `req_ready[winner]` = `can_accept`. All other `req_ready` bits are 0. The ready path is combinational from `req_valid`, `res_ready` and state.
- Accept (valid & ready on requester i), at the clock edge:
  - Register `res_data`, `res_id` = i and `res_err`.
  - Set `last` = i.
  - Next state is FULL.
- FULL with `res_ready` and no accept: next state is EMPTY. Data registers hold their stale values.
- FULL with `res_ready` and an accept in the same cycle: the old result drains and the new result loads. The state stays FULL, so throughput is 1 per cycle.
- FULL without `res_ready`: all outputs hold and every `req_ready` bit is 0.
- `last` updates only on an accept. Idle cycles do not rotate the pointer.
- Requesters that drop `req_valid` before acceptance are ignored; the block does not enforce valid stability.
- Pointer wrap: if NREQ is not a power of two, `last`+1 equal to NREQ wraps to 0.

## Timing
- Latency: a request accepted at edge k appears with `res_valid` = 1 after edge k. That is 1 cycle.
- Sustained throughput is 1 result per cycle while `res_ready` = 1.
- Reset (asynchronous, any time, including while FULL):
  - `res_valid`, `res_data`, `res_id`, `res_err` = 0.
  - `last` = NREQ-1, state = EMPTY.
  - `req_ready` = 0 while `rst_n` is low.
  - A pending result is discarded.
- After reset release, the first accept can occur at the first rising edge where `rst_n` is high.

## Configuration
- `LU_ARB_PERF_EN`:
  - Defined:
    - Adds output `op_count` (16 bits): a saturating count of accepted requests. It increments on each accept, holds at 16'hFFFF and resets to 0.
    - Adds output `err_count` (8 bits): a saturating count of accepts with an illegal opcode. It resets to 0.
  - Undefined: neither port nor its counter exists. All other behaviour is identical.

## Test plan
- Reset, single request: release reset; requester 2 sends a=8'hF0, b=8'h3C, op=4 (XOR) with `res_ready`=1. Required: `req_ready`=4'b0100 in the same cycle, then next cycle `res_valid`=1, `res_data`=8'hCC, `res_id`=2, `res_err`=0.
- Round-robin fairness: all 4 requesters hold valid continuously with `res_ready`=1. Grant order is 0,1,2,3,0,1,… and `res_valid` stays 1 every cycle after the first.
- Backpressure: result FULL and `res_ready`=0 for 3 cycles. `req_ready`=0 throughout, and `res_data`/`res_id` hold. When `res_ready` rises, a new accept occurs in that same cycle.
- Opcode sweep: a=8'hA5, b=8'h0F, ops 0–7. Required results:
  - op 0: 8'h05
  - op 1: 8'hAF
  - op 2: 8'hFA
  - op 3: 8'h50
  - op 4: 8'hAA
  - op 5: 8'h55
  - ops 6 and 7: 8'h00 with `res_err`=1
- Reset mid-operation: assert `rst_n`=0 while FULL between clock edges. `res_valid` drops immediately. After release, requester 0 wins over requester 3 when both are valid.
- `LU_ARB_PERF_EN` defined: 300 accepts including 2 illegal ops give `op_count`=300 and `err_count`=2. Force 70000 accepts and check `op_count` saturates at 16'hFFFF.
